ksa_swap_fsm: RTL
=================

Name: ksa_swap_fsm

Overview:
- Key-scheduling stage of the RC4 datapath. Sits directly downstream of the S-memory initialiser.
- After the initialiser's fin_strobe, it is started on the identity-filled s_memory. It then performs the 256-iteration KSA permutation: j = j + S[i] + key[i mod KEY_BYTES], then swap S[i] and S[j].
- It drives the s_memory port (address/data/wren, read q) through the top-level memory mux. On completion it pulses fin_strobe to the next stage (PRGA/decrypt).

Parameters:
- KEY_BYTES, 3: number of secret-key bytes; key port width is 8*KEY_BYTES.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request to run KSA; sampled only in IDLE.
- key  input  8*KEY_BYTES  secret key; byte 0 = key[8*KEY_BYTES-1 -: 8] (MSB-first); captured on accepted start.
- address  output  8  s_memory address.
- data  output  8  s_memory write data.
- wren  output  1  s_memory write enable.
- q  input  8  s_memory read data; valid the cycle after address is presented (registered address, 1-cycle read latency).
- busy  output  1  high in every state except IDLE.
- fin_strobe  output  1  one-cycle pulse when permutation is complete.

Behaviour:
- Reset (async, any time, including mid-run): state=IDLE, i=0, j=0, key-index k=0, si=0, sj=0, key_reg=0. Outputs address=0, data=0, wren=0, busy=0, fin_strobe=0. An interrupted run is abandoned; memory contents are left as-is.
- Outputs are decoded from state and registers; no combinational path from start or q to any output.
- States and per-cycle actions:
  - IDLE: wren=0, address=0. If start=1: key_reg<=key, i<=0, j<=0, k<=0, go to READ_I.
  - READ_I: address=i. Go to LATCH_I.
  - LATCH_I: si<=q; j<=j+q+key_reg byte k (8-bit modulo-256 sum, carries discarded). Go to READ_J.
  - READ_J: address=j (updated value). Go to LATCH_J.
  - LATCH_J: sj<=q. Go to WRITE_I.
  - WRITE_I: address=i, data=sj, wren=1. Go to WRITE_J.
  - WRITE_J: address=j, data=si, wren=1.
    - If i==255, go to DONE.
    - Otherwise i<=i+1; k<=(k==KEY_BYTES-1)?0:k+1; go to READ_I.
  - DONE: fin_strobe=1 for exactly one cycle. Go to IDLE.
- Timing:
  - Each iteration takes 6 cycles.
  - With start sampled at edge 0, iteration n occupies cycles 6n+1..6n+6.
  - fin_strobe is high in cycle 1537. busy is high in cycles 1..1537.
- Key index k is a modulo-KEY_BYTES counter; no divider.
- i==j: WRITE_I then WRITE_J hit the same address. The final value is si, the original value, which is the correct no-op swap.
- start while busy: ignored. No restart and no queuing.
- start held high across DONE→IDLE: a new run starts on the first IDLE cycle in which start is sampled high.
- i wraps never: the run terminates at i==255. j wraps naturally modulo 256.
- key changes during a run have no effect, because key_reg was captured at start.

Test Plan:
1. Reset values: assert rst mid-cycle with no clock edge → all outputs 0 immediately. Release rst, hold start=0 for 20 cycles → wren stays 0, busy stays 0.
2. Key byte order: preload S[x]=x, key=24'h010203, pulse start.
   - Iteration 0 writes S[0]=1, S[1]=0.
   - Iteration 1 reads S[1]=0, j=3, writes S[1]=3, S[3]=0.
   - Check the address/data/wren sequence cycle-by-cycle against the state table.
3. Zero key and i==j: preload identity, key=0.
   - Iterations 0 and 1 write S[0]=0 and S[1]=1 (i==j case, contents unchanged).
   - Iteration 2 sets j=3 and swaps, giving S[2]=3, S[3]=2.
4. Full run: key=24'h000249, then compare the final 256-byte memory against a reference-model KSA.
   - fin_strobe is high only in cycle 1537 after start, for one cycle.
   - busy falls the following cycle.
5. Start during busy: pulse start at cycles 100 and 1000 of a run → no effect; fin_strobe still occurs at cycle 1537 and the memory result is unchanged.
6. Reset mid-run at cycle 700, then pulse start with re-initialised identity memory → the run restarts from i=0, j=0 and completes with the same result as scenario 4.

Source files
------------

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling stage: permutes an identity-filled S-memory with the secret key.
// One iteration = read S[i], read S[j], write S[i], write S[j]; six cycles per iteration.
module ksa_swap_fsm #(
    parameter int KEY_BYTES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             address,
    output logic [7:0]             data,
    output logic                   wren,
    input  logic [7:0]             q,
    output logic                   busy,
    output logic                   fin_strobe
);

    localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ_I,
        S_LATCH_I,
        S_READ_J,
        S_LATCH_J,
        S_WRITE_I,
        S_WRITE_J,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_si;
    logic [7:0]             r_sj;
    logic [KW-1:0]          r_k;
    logic [8*KEY_BYTES-1:0] r_key_reg;

    logic [7:0]             w_key_byte [KEY_BYTES];
    logic [7:0]             w_key_sel;
    logic                   w_last_iter;

    // Byte 0 is the most significant byte of the key port.
    for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_bytes
        assign w_key_byte[gi] = r_key_reg[8*(KEY_BYTES-gi)-1 -: 8];
    end

    always_comb begin
        w_key_sel = w_key_byte[0];
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (r_k == KW'(b)) begin
                w_key_sel = w_key_byte[b];
            end
        end
    end

    assign w_last_iter = (r_i == 8'hFF);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    w_state_next = start ? S_READ_I : S_IDLE;
            S_READ_I:  w_state_next = S_LATCH_I;
            S_LATCH_I: w_state_next = S_READ_J;
            S_READ_J:  w_state_next = S_LATCH_J;
            S_LATCH_J: w_state_next = S_WRITE_I;
            S_WRITE_I: w_state_next = S_WRITE_J;
            S_WRITE_J: w_state_next = w_last_iter ? S_DONE : S_READ_I;
            S_DONE:    w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // Datapath registers: indices, latched S values and captured key
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= '0;
            r_si      <= '0;
            r_sj      <= '0;
            r_key_reg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_key_reg <= key;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_k       <= '0;
                    end
                end
                S_LATCH_I: begin
                    r_si <= q;
                    r_j  <= r_j + q + w_key_sel;
                end
                S_LATCH_J: begin
                    r_sj <= q;
                end
                S_WRITE_J: begin
                    if (!w_last_iter) begin
                        r_i <= r_i + 8'd1;
                        r_k <= (r_k == KW'(KEY_BYTES-1)) ? '0 : r_k + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode; writing S[i] before S[j] makes the i==j case a no-op swap.
    always_comb begin
        address    = 8'd0;
        data       = 8'd0;
        wren       = 1'b0;
        busy       = (r_state != S_IDLE);
        fin_strobe = 1'b0;
        case (r_state)
            S_READ_I: begin
                address = r_i;
            end
            S_READ_J: begin
                address = r_j;
            end
            S_WRITE_I: begin
                address = r_i;
                data    = r_sj;
                wren    = 1'b1;
            end
            S_WRITE_J: begin
                address = r_j;
                data    = r_si;
                wren    = 1'b1;
            end
            S_DONE: begin
                fin_strobe = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
